jam_cost_table: RTL and testbench

JAM_COST_TABLE -- requirements
Module: jam_cost_table

---
 rtl/jam_pkg.sv | 18 +
 rtl/jam_cost_table_if.sv | 18 +
 rtl/jam_cost_mem.sv | 40 ++++
 rtl/jam_cost_table.sv | 121 ++++++++++++
 tb/tb_jam_cost_table.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/jam_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | jam_pkg : shared constants and FSM state type for jam_cost_table    |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
package jam_pkg;

  localparam int N_JOB  = 8;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/jam_cost_table_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | jam_cost_table_if : valid/ready cost-beat stream into the table     |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
interface jam_cost_table_if #(
  parameter int COST_W = 7
);

  logic              in_valid;
  logic              in_ready;
  logic [COST_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface
`default_nettype wire

// File: rtl/jam_cost_mem.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | jam_cost_mem : cost register array, sync write, registered read     |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module jam_cost_mem #(
  parameter int COST_W = 7,
  parameter int ADDR_W = 6
) (
  input  wire logic              CLK,
  input  wire logic              RST_N,
  input  wire logic              wr_en,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [COST_W-1:0] wr_data,
  input  wire logic              rd_zero,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output logic      [COST_W-1:0] rd_data
);

  logic [COST_W-1:0] mem [0:(1<<ADDR_W)-1];

  // The array itself has no reset; only the read register does.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_data <= '0;
    end else if (rd_zero) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/jam_cost_table.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | jam_cost_table : loads an N_JOB x N_JOB cost matrix, serves lookups |
// | and reports the sum of row minimums as a lower bound.               |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module jam_cost_table #(
  parameter int N_JOB  = 8,
  parameter int COST_W = 7
) (
  input  wire logic              CLK,
  input  wire logic              RST_N,
  input  wire logic              clear,
  jam_cost_table_if.slave        in_bus,
  input  wire logic [2:0]        W,
  input  wire logic [2:0]        J,
  output logic      [COST_W-1:0] Cost,
  output logic                   table_ready,
  output logic      [9:0]        lower_bound
);

  import jam_pkg::*;

  localparam int                JOB_W  = $clog2(N_JOB);
  localparam int                ADDR_W = 2 * JOB_W;
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_JOB * N_JOB - 1);
  localparam logic [JOB_W-1:0]  J_LAST = JOB_W'(N_JOB - 1);

  state_t            state;
  state_t            state_nxt;
  logic              armed;
  logic              in_ready_c;
  logic              accept;
  logic [ADDR_W-1:0] k;
  logic [COST_W-1:0] row_min;
  logic [COST_W-1:0] cand;
  logic [SUM_W-1:0]  acc;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clear wins over a final beat
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = LOAD;
    end else if (state == LOAD && accept && k == K_LAST) begin
      state_nxt = READY;
    end
  end

  // Output logic; armed keeps in_ready low until the first edge after reset
  always_comb begin
    in_ready_c = armed && (state == LOAD);
  end

  assign in_bus.in_ready = in_ready_c;
  assign accept          = in_bus.in_valid && in_ready_c;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // First beat of a row seeds the minimum, later beats compare against it
  always_comb begin
    cand = row_min;
    if (k[JOB_W-1:0] == '0 || in_bus.in_data < row_min) begin
      cand = in_bus.in_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k           <= '0;
      row_min     <= '0;
      acc         <= '0;
      table_ready <= 1'b0;
    end else begin
      table_ready <= (state_nxt == READY);
      if (clear) begin
        k       <= '0;
        row_min <= '0;
        acc     <= '0;
      end else if (accept) begin
        k       <= k + 1'b1;
        row_min <= cand;
        if (k[JOB_W-1:0] == J_LAST) begin
          acc <= acc + {{(SUM_W-COST_W){1'b0}}, cand};
        end
      end
    end
  end

  assign lower_bound = acc;

  jam_cost_mem #(
    .COST_W (COST_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (accept && !clear),
    .wr_addr (k),
    .wr_data (in_bus.in_data),
    .rd_zero (clear || state != READY),
    .rd_addr ({W, J}),
    .rd_data (Cost)
  );

endmodule
`default_nettype wire

// File: tb/tb_jam_cost_table.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_jam_cost_table : directed scoreboard bench for jam_cost_table    |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module tb_jam_cost_table;

  import jam_pkg::*;

  logic              CLK   = 1'b0;
  logic              RST_N = 1'b0;
  logic              clear = 1'b0;
  logic [2:0]        W     = '0;
  logic [2:0]        J     = '0;
  logic [COST_W-1:0] Cost;
  logic              table_ready;
  logic [SUM_W-1:0]  lower_bound;

  jam_cost_table_if #(.COST_W(COST_W)) bus ();

  jam_cost_table #(
    .N_JOB  (8),
    .COST_W (7)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .clear       (clear),
    .in_bus      (bus.slave),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .table_ready (table_ready),
    .lower_bound (lower_bound)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  logic lk_issue = 1'b0;
  logic lk_due   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int cost_of(input int mode, input int w, input int j);
    case (mode)
      0:       return w * 8 + j;
      1:       return (w == j) ? 1 : 127;
      default: return 5;
    endcase
  endfunction

  // Lookup results are due one cycle after the address is presented
  always @(posedge CLK) lk_due <= lk_issue;

  always @(negedge CLK) begin
    if (lk_due) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cost_lookup actual=%0d required=none_pending", Cost);
      end else begin
        check("cost_lookup", 32'(Cost), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    lk_issue = 1'b0;
  endtask

  task automatic lookup(input int w, input int j, input int exp);
    W        = 3'(w);
    J        = 3'(j);
    lk_issue = 1'b1;
    exp_q.push_back(exp);
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic load(input int mode, input int nbeats, input bit gaps);
    for (int k = 0; k < nbeats; k++) begin
      if (k == 63) begin
        check("in_ready_before_last", 32'(bus.in_ready), 1);
        check("table_ready_before_last", 32'(table_ready), 0);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = COST_W'(cost_of(mode, k / 8, k % 8));
      step();
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_data  = '1;
        step();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_loaded(input int lb);
    check("in_ready_after_load", 32'(bus.in_ready), 0);
    check("table_ready_after_load", 32'(table_ready), 1);
    check("lower_bound", 32'(lower_bound), 32'(lb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    step();
    step();
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_table_ready", 32'(table_ready), 0);
    check("rst_cost", 32'(Cost), 0);
    check("rst_lower_bound", 32'(lower_bound), 0);
    RST_N = 1'b1;
    step();
    check("in_ready_after_release", 32'(bus.in_ready), 1);

    // Ramp costs, back-to-back
    load(0, 64, 1'b0);
    check_loaded(224);
    lookup(3, 5, 29);
    lookup(0, 0, 0);
    lookup(7, 7, 63);
    lookup(1, 2, 10);

    // Diagonal ones, everything else saturated
    do_clear();
    check("clear_cost", 32'(Cost), 0);
    check("clear_table_ready", 32'(table_ready), 0);
    check("clear_lower_bound", 32'(lower_bound), 0);
    check("clear_in_ready", 32'(bus.in_ready), 1);
    load(1, 64, 1'b0);
    check_loaded(8);
    lookup(2, 2, 1);
    lookup(2, 3, 127);

    // Ramp again with a bubble after every beat
    do_clear();
    load(0, 64, 1'b1);
    check_loaded(224);
    lookup(3, 5, 29);
    lookup(6, 1, 49);

    // Clear coincides with the 40th beat, then a full all-5 load
    do_clear();
    load(2, 39, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 7'd5;
    clear        = 1'b1;
    step();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clear40_table_ready", 32'(table_ready), 0);
    check("clear40_in_ready", 32'(bus.in_ready), 1);
    load(2, 64, 1'b0);
    check_loaded(40);
    lookup(4, 4, 5);

    // Reset pulse after 20 beats of a fresh load
    do_clear();
    load(0, 20, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    check("midload_rst_table_ready", 32'(table_ready), 0);
    check("midload_rst_cost", 32'(Cost), 0);
    check("midload_rst_in_ready", 32'(bus.in_ready), 0);
    check("midload_rst_lower_bound", 32'(lower_bound), 0);
    step();
    RST_N = 1'b1;
    step();
    load(0, 64, 1'b0);
    check_loaded(224);
    lookup(3, 5, 29);

    // Stray valid beats while READY must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    for (int i = 0; i < 10; i++) step();
    bus.in_valid = 1'b0;
    check("ready_ignore_table_ready", 32'(table_ready), 1);
    check("ready_ignore_lower_bound", 32'(lower_bound), 224);
    lookup(0, 1, 1);
    lookup(1, 1, 9);
    lookup(7, 7, 63);
    step();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
